spi_tx_packetizer: RTL and testbench
====================================

SPI_TX_PACKETIZER -- requirements
Module: spi_tx_packetizer

Interface
REQ-001 The block SHALL have parameter DEPTH_G, default 16, packet buffer depth in bytes (power of 2, 4..256).
REQ-002 The block SHALL have parameter NUM_BYTES_W_G, default 32, width of the num_bytes output.
REQ-003 The block SHALL have port clk_in  in  1  the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst_in  in  1  asynchronous, active-low reset.
REQ-005 The block SHALL have ports s_axis_tdata  in  8, s_axis_tvalid  in  1, s_axis_tready  out  1, s_axis_tlast  in  1, the upstream byte stream.
REQ-006 The block SHALL have ports m_axis_tdata  out  8, m_axis_tvalid  out  1, m_axis_tready  in  1, m_axis_tlast  out  1, feeding the SPI master s_axis port.
REQ-007 The block SHALL have port trigger  out  1, a one-cycle start pulse to the SPI master.
REQ-008 The block SHALL have port num_bytes  out  NUM_BYTES_W_G, the byte count of the current packet.
REQ-009 The block SHALL have port spi_busy  in  1, the SPI master busy flag.
REQ-010 The block SHALL have port trunc_err  out  1, a one-cycle pulse on packet truncation.

Function
REQ-011 The block SHALL implement FSM states FILL, TRIG, DRAIN and WAIT_IDLE.
REQ-012 In FILL the block SHALL assert s_axis_tready, write each accepted byte (tvalid&tready) to the buffer and increment a byte counter.
REQ-013 FILL SHALL go to TRIG on the cycle after an accepted byte with s_axis_tlast=1, or after the accepted byte that makes the count equal DEPTH_G.
REQ-014 On closing by count without tlast, the block SHALL pulse trunc_err for one cycle and set a discard flag.
REQ-015 In TRIG the block SHALL assert trigger for exactly one cycle, then go to DRAIN.
REQ-016 num_bytes SHALL equal the packet byte count from the TRIG cycle until re-entry to FILL, and SHALL be 0 in FILL.
REQ-017 In DRAIN the block SHALL present buffered bytes in write order on m_axis, hold tdata/tvalid/tlast stable while tready=0, and advance only on tvalid&tready.
REQ-018 m_axis_tlast SHALL be 1 only with the final byte of the packet.
REQ-019 After the final handshake the block SHALL go to WAIT_IDLE.
REQ-020 WAIT_IDLE SHALL go to FILL on the first cycle with spi_busy=0 and the discard flag clear.
REQ-021 While the discard flag is set, s_axis_tready SHALL be 1 in TRIG/DRAIN/WAIT_IDLE, accepted bytes SHALL be dropped, and an accepted tlast SHALL clear the flag.
REQ-022 Outside FILL with the discard flag clear, s_axis_tready SHALL be 0.
REQ-023 Packets SHALL be 1..DEPTH_G bytes; a zero-length packet cannot occur.

Reset
REQ-024 On rst_in=0 the block SHALL enter FILL asynchronously, clear counters, pointers and the discard flag, and discard buffer contents.
REQ-025 During reset s_axis_tready, m_axis_tvalid, m_axis_tlast, trigger and trunc_err SHALL be 0, and num_bytes and m_axis_tdata SHALL be 0.
REQ-026 Reset asserted mid-packet SHALL abandon the packet with no further trigger or m_axis beats for it.
REQ-027 s_axis_tready SHALL rise in the first cycle after rst_in deasserts.

Configuration
REQ-028 With macro SPI_TX_PACKETIZER_STATS_EN defined, the block SHALL add outputs pkt_count (16-bit, +1 per TRIG) and trunc_count (16-bit, +1 per trunc_err), both reset to 0 and wrapping at 0xFFFF->0.
REQ-029 Without SPI_TX_PACKETIZER_STATS_EN, these ports and counters SHALL not exist, and all other behaviour SHALL be identical.

Verification
REQ-030 Bytes 0x37,0x48,0x59 (tlast on 0x59), m_axis_tready=1 -> one trigger pulse, num_bytes=3, m_axis beats 0x37,0x48,0x59 with tlast on 0x59 only.
REQ-031 Same packet with m_axis_tready toggling every cycle -> the same 3 beats in order, data held stable while stalled, no duplicated or lost bytes.
REQ-032 DEPTH_G=4, 6 bytes 0x01..0x06 (tlast on 0x06) -> trunc_err pulse, num_bytes=4, beats 0x01..0x04 (tlast on 0x04), 0x05/0x06 dropped, then FILL.
REQ-033 spi_busy held 1 for 20 cycles after the last beat -> s_axis_tready stays 0 until the cycle after spi_busy falls.
REQ-034 rst_in low during DRAIN after beat 1 of 3 -> all outputs 0; the next packet 0xAA (tlast) -> trigger, num_bytes=1, single beat 0xAA.
REQ-035 With SPI_TX_PACKETIZER_STATS_EN, two normal packets plus one truncated packet -> pkt_count=3, trunc_count=1.

Source files
------------

// File: rtl/spi_tx_packetizer.sv
// Collects one upstream byte packet, pulses trigger to the SPI master, then replays the packet on m_axis.
// Optional statistics outputs (pkt_count, trunc_count) are enabled by defining SPI_TX_PACKETIZER_STATS_EN.
module spi_tx_packetizer #(
  parameter int DEPTH_G       = 16,
  parameter int NUM_BYTES_W_G = 32
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [7:0]               s_axis_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic                     s_axis_tlast,
  output logic [7:0]               m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic                     trigger,
  output logic [NUM_BYTES_W_G-1:0] num_bytes,
  input  logic                     spi_busy,
`ifdef SPI_TX_PACKETIZER_STATS_EN
  output logic [15:0]              pkt_count,
  output logic [15:0]              trunc_count,
`endif
  output logic                     trunc_err
);

  // state     | meaning
  // FILL      | accept upstream bytes into the buffer
  // TRIG      | one-cycle start pulse to the SPI master
  // DRAIN     | replay buffered bytes on m_axis
  // WAIT_IDLE | wait for SPI idle and any truncated tail to be flushed
  localparam int AW = $clog2(DEPTH_G);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {FILL = 2'd0, TRIG = 2'd1, DRAIN = 2'd2, WAIT_IDLE = 2'd3} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [7:0]    mem [DEPTH_G];
  logic [CW-1:0] cnt;
  logic [AW-1:0] rd_ptr;
  logic          run;
  logic          discard;
  logic          fill_acc;
  logic          fill_close;
  logic          fill_trunc;
  logic          last_beat;
  logic          drain_acc;
  logic          drop_last;

  assign fill_acc   = (state == FILL) && run && s_axis_tvalid;
  assign fill_close = fill_acc && (s_axis_tlast || (cnt == CW'(DEPTH_G - 1)));
  assign fill_trunc = fill_acc && !s_axis_tlast && (cnt == CW'(DEPTH_G - 1));
  assign last_beat  = (CW'(rd_ptr) == (cnt - CW'(1)));
  assign drain_acc  = (state == DRAIN) && m_axis_tready;
  assign drop_last  = discard && (state != FILL) && s_axis_tvalid && s_axis_tlast;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= FILL;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:      if (fill_close) state_nxt = TRIG;
      TRIG:      state_nxt = DRAIN;
      DRAIN:     if (drain_acc && last_beat) state_nxt = WAIT_IDLE;
      WAIT_IDLE: if (!spi_busy && !discard) state_nxt = FILL;
      default:   state_nxt = FILL;
    endcase
  end

  always_comb begin
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tdata  = '0;
    trigger       = 1'b0;
    num_bytes     = '0;
    // run holds tready low through reset and releases it on the first clock after
    if (run) s_axis_tready = (state == FILL) || discard;
    case (state)
      TRIG: begin
        trigger   = 1'b1;
        num_bytes = NUM_BYTES_W_G'(cnt);
      end
      DRAIN: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = mem[rd_ptr];
        m_axis_tlast  = last_beat;
        num_bytes     = NUM_BYTES_W_G'(cnt);
      end
      WAIT_IDLE: num_bytes = NUM_BYTES_W_G'(cnt);
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      run       <= 1'b0;
      cnt       <= '0;
      rd_ptr    <= '0;
      discard   <= 1'b0;
      trunc_err <= 1'b0;
    end else begin
      run       <= 1'b1;
      trunc_err <= fill_trunc;
      if (fill_acc)                                   cnt <= cnt + CW'(1);
      else if (state == WAIT_IDLE && state_nxt == FILL) cnt <= '0;
      if (state == TRIG)  rd_ptr <= '0;
      else if (drain_acc) rd_ptr <= rd_ptr + AW'(1);
      if (fill_trunc)     discard <= 1'b1;
      else if (drop_last) discard <= 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (fill_acc) mem[cnt[AW-1:0]] <= s_axis_tdata;
  end

`ifdef SPI_TX_PACKETIZER_STATS_EN
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pkt_count   <= '0;
      trunc_count <= '0;
    end else begin
      if (state == TRIG) pkt_count   <= pkt_count + 16'd1;
      if (trunc_err)     trunc_count <= trunc_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_spi_tx_packetizer.sv
// Randomized bench for spi_tx_packetizer (DEPTH_G=4) with a packet-level reference model.
// Stats checks are compiled in when SPI_TX_PACKETIZER_STATS_EN is defined.
module tb_spi_tx_packetizer;
  localparam int DEPTH = 4;
  localparam int NBW   = 32;

  logic           clk_in = 1'b0;
  logic           rst_in = 1'b0;
  logic [7:0]     s_axis_tdata = '0;
  logic           s_axis_tvalid = 1'b0;
  logic           s_axis_tready;
  logic           s_axis_tlast = 1'b0;
  logic [7:0]     m_axis_tdata;
  logic           m_axis_tvalid;
  logic           m_axis_tready = 1'b0;
  logic           m_axis_tlast;
  logic           trigger;
  logic [NBW-1:0] num_bytes;
  logic           spi_busy = 1'b0;
  logic           trunc_err;
`ifdef SPI_TX_PACKETIZER_STATS_EN
  logic [15:0]    pkt_count;
  logic [15:0]    trunc_count;
`endif

  always #5 clk_in = ~clk_in;

  spi_tx_packetizer #(.DEPTH_G(DEPTH), .NUM_BYTES_W_G(NBW)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .trigger       (trigger),
    .num_bytes     (num_bytes),
    .spi_busy      (spi_busy),
`ifdef SPI_TX_PACKETIZER_STATS_EN
    .pkt_count     (pkt_count),
    .trunc_count   (trunc_count),
`endif
    .trunc_err     (trunc_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: a packet of L bytes yields min(L,DEPTH) beats, last one tagged
  logic [7:0] pkt[$];
  logic [8:0] exp_beats[$];
  int         exp_len[$];
  int         exp_trig = 0, exp_trunc = 0, seen_trig = 0, seen_trunc = 0;
  int         stat_pkts = 0, stat_trunc = 0;
  int         cur_len = 0;

  task automatic model_push();
    int n;
    n = (pkt.size() > DEPTH) ? DEPTH : pkt.size();
    for (int i = 0; i < n; i++) exp_beats.push_back({(i == n - 1), pkt[i]});
    exp_len.push_back(n);
    exp_trig++;
    stat_pkts++;
    if (pkt.size() > DEPTH) begin
      exp_trunc++;
      stat_trunc++;
    end
  endtask

  int   sink_mode = 0;
  logic man_ready = 1'b0;
  logic man_busy  = 1'b0;
  logic busy_rand = 1'b0;

  always @(posedge clk_in) begin
    #2;
    case (sink_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = ~m_axis_tready;
      2:       m_axis_tready = ($urandom_range(0, 1) == 1);
      default: m_axis_tready = man_ready;
    endcase
    spi_busy = busy_rand ? ($urandom_range(0, 3) == 0) : man_busy;
  end

  logic       prev_stall = 1'b0;
  logic [8:0] prev_beat  = '0;

  always @(negedge clk_in) begin
    if (!rst_in) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("hold_valid", m_axis_tvalid, 1);
        check_eq("hold_beat", {m_axis_tlast, m_axis_tdata}, prev_beat);
      end
      if (trigger) begin
        seen_trig++;
        if (exp_len.size() == 0) check_eq("unexpected_trigger", trigger, 0);
        else begin
          cur_len = exp_len.pop_front();
          check_eq("num_bytes_trig", num_bytes, cur_len);
        end
      end
      if (trunc_err) seen_trunc++;
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_beats.size() == 0) check_eq("unexpected_beat", m_axis_tvalid, 0);
        else check_eq("beat", {m_axis_tlast, m_axis_tdata}, exp_beats.pop_front());
        check_eq("num_bytes_drain", num_bytes, cur_len);
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_beat  = {m_axis_tlast, m_axis_tdata};
    end
  end

  task automatic send_pkt(input int max_gap);
    int wait_cyc;
    int gap;
    model_push();
    for (int i = 0; i < pkt.size(); i++) begin
      wait_cyc      = 0;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = pkt[i];
      s_axis_tlast  = (i == pkt.size() - 1);
      @(negedge clk_in);
      while (!s_axis_tready && wait_cyc < 300) begin
        wait_cyc++;
        @(negedge clk_in);
      end
      if (wait_cyc >= 300) check_eq("s_ready_timeout", s_axis_tready, 1);
      @(posedge clk_in); #1;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
      repeat (gap) begin
        @(posedge clk_in); #1;
      end
    end
  endtask

  task automatic wait_drained();
    int n;
    n = 0;
    while ((exp_beats.size() != 0 || exp_len.size() != 0) && n < 3000) begin
      @(negedge clk_in);
      n++;
    end
    if (n >= 3000) check_eq("drain_timeout", exp_beats.size(), 0);
    repeat (3) @(posedge clk_in);
    #1;
  endtask

  task automatic check_outputs_zero(input string p);
    check_eq({p, "_s_tready"}, s_axis_tready, 0);
    check_eq({p, "_m_tvalid"}, m_axis_tvalid, 0);
    check_eq({p, "_m_tlast"},  m_axis_tlast, 0);
    check_eq({p, "_m_tdata"},  m_axis_tdata, 0);
    check_eq({p, "_trigger"},  trigger, 0);
    check_eq({p, "_trunc"},    trunc_err, 0);
    check_eq({p, "_num"},      num_bytes, 0);
`ifdef SPI_TX_PACKETIZER_STATS_EN
    check_eq({p, "_pkt_cnt"},   pkt_count, 0);
    check_eq({p, "_trunc_cnt"}, trunc_count, 0);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int n;
    int len;

    repeat (3) @(negedge clk_in);
    check_outputs_zero("rst");
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    check_eq("ready_after_rst", s_axis_tready, 1);

    // basic packet, sink always ready
    sink_mode = 0;
    t0 = seen_trig;
    pkt = '{8'h37, 8'h48, 8'h59};
    send_pkt(0);
    wait_drained();
    check_eq("basic_trig_cnt", seen_trig - t0, 1);
    check_eq("basic_fill_num", num_bytes, 0);

    // same packet, sink toggling every cycle
    sink_mode = 1;
    t0 = seen_trig;
    pkt = '{8'h37, 8'h48, 8'h59};
    send_pkt(0);
    wait_drained();
    check_eq("toggle_trig_cnt", seen_trig - t0, 1);

    // overlong packet truncated to DEPTH
    sink_mode = 0;
    t0 = seen_trunc;
    pkt = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send_pkt(0);
    wait_drained();
    check_eq("trunc_pulse_cnt", seen_trunc - t0, 1);
    check_eq("trunc_back_fill", s_axis_tready, 1);
    check_eq("trunc_fill_num", num_bytes, 0);

    // SPI busy holds off the next fill
    man_busy = 1'b1;
    pkt = '{8'h11};
    send_pkt(0);
    n = 0;
    while (exp_beats.size() != 0 && n < 300) begin
      @(negedge clk_in);
      n++;
    end
    if (n >= 300) check_eq("busy_drain_timeout", exp_beats.size(), 0);
    repeat (20) begin
      @(negedge clk_in);
      check_eq("ready_while_busy", s_axis_tready, 0);
    end
    @(posedge clk_in); #1;
    man_busy = 1'b0;
    @(negedge clk_in);
    check_eq("ready_busy_fall_cycle", s_axis_tready, 0);
    @(negedge clk_in);
    check_eq("ready_after_busy", s_axis_tready, 1);
    @(posedge clk_in); #1;

    // reset in the middle of DRAIN, after the first beat
    sink_mode = 3;
    man_ready = 1'b0;
    pkt = '{8'hC1, 8'hC2, 8'hC3};
    send_pkt(0);
    n = 0;
    @(negedge clk_in);
    while (!m_axis_tvalid && n < 300) begin
      @(negedge clk_in);
      n++;
    end
    if (n >= 300) check_eq("mid_rst_valid_timeout", m_axis_tvalid, 1);
    @(posedge clk_in); #1;
    man_ready = 1'b1;
    @(posedge clk_in); #1;
    man_ready = 1'b0;
    @(negedge clk_in);
    check_eq("mid_rst_beats_left", exp_beats.size(), 2);
    #1;
    rst_in = 1'b0;
    #1;
    check_outputs_zero("mid_rst");
    exp_beats.delete();
    exp_len.delete();
    stat_pkts  = 0;
    stat_trunc = 0;
    repeat (2) @(negedge clk_in);
    rst_in    = 1'b1;
    sink_mode = 0;
    @(posedge clk_in); #1;
    t0 = seen_trig;
    pkt = '{8'hAA};
    send_pkt(0);
    wait_drained();
    check_eq("post_rst_trig_cnt", seen_trig - t0, 1);

    // two more packets, one truncated: three packets since reset, one truncation
    pkt = '{8'h21, 8'h22};
    send_pkt(1);
    pkt = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
    send_pkt(1);
    wait_drained();
`ifdef SPI_TX_PACKETIZER_STATS_EN
    check_eq("stats_pkt_count", pkt_count, stat_pkts);
    check_eq("stats_trunc_count", trunc_count, stat_trunc);
`endif

    // randomized phase: random lengths, gaps, sink stalls and SPI busy
    sink_mode = 2;
    busy_rand = 1'b1;
    for (int p = 0; p < 40; p++) begin
      len = $urandom_range(1, DEPTH + 2);
      pkt.delete();
      for (int b = 0; b < len; b++) pkt.push_back(8'($urandom_range(0, 255)));
      send_pkt(2);
    end
    busy_rand = 1'b0;
    man_busy  = 1'b0;
    wait_drained();

    check_eq("total_triggers", seen_trig, exp_trig);
    check_eq("total_truncs", seen_trunc, exp_trunc);
    check_eq("end_idle_ready", s_axis_tready, 1);
`ifdef SPI_TX_PACKETIZER_STATS_EN
    check_eq("end_pkt_count", pkt_count, stat_pkts);
    check_eq("end_trunc_count", trunc_count, stat_trunc);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
